// File: rtl/config_word_loader.sv
// config_word_loader: streams config words into the latch bank as setup / one-hot strobe / hold triplets
module config_word_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WORD_W-1:0]    io_in_bits,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic [4:0]           io_word_count
);
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, DONE} state_t;
    localparam logic [4:0] LAST = 5'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] ONE = {{(NUM_WORDS-1){1'b0}}, 1'b1};
    state_t state_q, state_d;
    logic [4:0] idx_q, idx_d, cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [NUM_WORDS-1:0] en_q, en_d;
    logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (io_start) begin
                state_d = LOAD;
                idx_d   = '0;
                cnt_d   = '0;
            end
            LOAD: if (io_in_valid && ready_q) begin
                data_d  = io_in_bits;
                state_d = SETUP;
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = cnt_q + 5'd1;
            end
            STROBE: state_d = HOLD;
            HOLD: begin
                state_d = (idx_q == LAST) ? DONE : LOAD;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + 5'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they line up with the state register
        ready_d = state_d == LOAD;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        en_d    = (state_d == STROBE) ? ONE << idx_d : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign io_in_ready   = ready_q;
    assign io_d_out      = data_q;
    assign io_configs_en = en_q;
    assign io_busy       = busy_q;
    assign io_done       = done_q;
    assign io_word_count = cnt_q;
endmodule

// File: tb/tb_config_word_loader.sv
// tb_config_word_loader: timeline model of accept/strobe/done cycles checked every cycle, plus directed literals
module tb_config_word_loader;
    localparam logic [31:0] BASE = 32'hC0DE_0000;
    logic clk = 1'b0, rst_i = 1'b1, st_i = 1'b0, vld_i = 1'b0;
    logic [31:0] bits_i = '0;
    logic io_in_ready, io_busy, io_done;
    logic [31:0] io_d_out;
    logic [24:0] io_configs_en, prev_en = '0;
    logic [4:0] io_word_count;
    int n_tests = 0, n_fail = 0, cyc = 0, s = 0;
    bit chk_on = 0;
    // Model: a load is a list of acceptance cycles; everything else is an offset from the last one
    bit m_act = 0;
    int m_k = 0, m_open = 0, m_acc = 0;
    logic [31:0] m_data = '0;

    config_word_loader dut (
        .clk(clk), .reset(rst_i), .io_start(st_i), .io_in_valid(vld_i),
        .io_in_ready(io_in_ready), .io_in_bits(bits_i), .io_d_out(io_d_out),
        .io_configs_en(io_configs_en), .io_busy(io_busy), .io_done(io_done),
        .io_word_count(io_word_count)
    );

    always #5 clk = ~clk;

    function automatic logic m_busy(int c);
        return m_act && !(m_k == 25 && c >= m_acc + 5);
    endfunction
    function automatic logic m_ready(int c);
        return m_busy(c) && m_k < 25 && c >= m_open;
    endfunction
    function automatic logic [24:0] m_en(int c);
        logic [24:0] one = 25'd1;
        return (m_busy(c) && m_k > 0 && c == m_acc + 2) ? one << (m_k - 1) : '0;
    endfunction
    function automatic logic m_done(int c);
        return m_act && m_k == 25 && c == m_acc + 4;
    endfunction
    function automatic int m_cnt(int c);
        return (m_k == 0) ? 0 : ((c >= m_acc + 2) ? m_k : m_k - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_i) begin
            m_act  <= 0;
            m_k    <= 0;
            m_data <= '0;
        end else if (!m_busy(cyc) && st_i) begin
            m_act  <= 1;
            m_k    <= 0;
            m_open <= cyc + 1;
        end else if (m_ready(cyc) && vld_i) begin
            m_data <= bits_i;
            m_acc  <= cyc;
            m_k    <= m_k + 1;
            m_open <= cyc + 4;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) if (chk_on) begin
        check("ready", io_in_ready, m_ready(cyc));
        check("busy", io_busy, m_busy(cyc));
        check("done", io_done, m_done(cyc));
        check("en", io_configs_en, m_en(cyc));
        check("d_out", io_d_out, m_data);
        check("word_count", io_word_count, m_cnt(cyc));
        check("en_onehot0", $onehot0(io_configs_en), 1);
        check("en_consecutive", prev_en != 0 && io_configs_en != 0, 0);
        prev_en <= io_configs_en;
    end

    task automatic drive(input logic st, input logic rs, input logic v, input logic [31:0] b);
        @(negedge clk);
        st_i = st; rst_i = rs; vld_i = v; bits_i = b;
    endtask

    task automatic idle_stim(input logic [31:0] dout_exp);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'hFFFF_FFFF);
            check("idle_ready", io_in_ready, 0);
            check("idle_en", io_configs_en, 0);
            check("idle_dout", io_d_out, dout_exp);
        end
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        check("rst_busy", io_busy, 0);
        check("rst_dout", io_d_out, 0);
        check("rst_count", io_word_count, 0);
        rst_i = 0;
        idle_stim(32'h0);
        // Full load, valid always high
        drive(1, 0, 1, BASE);
        s = cyc;
        for (int i = 1; i <= 105; i++) begin
            drive(0, 0, 1, BASE + 32'(m_k));
            if (i == 1) check("full_busy_rise", io_busy, 1);
            if (i == 3) check("full_w0_en", io_configs_en, 25'h1);
            if (i == 4) check("full_w0_dout", io_d_out, BASE);
            if (i == 7) check("full_w1_en", io_configs_en, 25'h2);
            if (i == 99) check("full_w24_en", io_configs_en, 25'h100_0000);
            if (i == 100) check("full_pre_done", io_done, 0);
            if (i == 101) check("full_done", io_done, 1);
            if (i == 102) check("full_idle", io_busy, 0);
            if (i == 102) check("full_count", io_word_count, 25);
        end
        idle_stim(BASE + 32'd24);
        // Backpressure: valid low for 3 cycles where word 5 would be accepted
        drive(1, 0, 1, BASE);
        for (int i = 1; i <= 108; i++) begin
            drive(0, 0, !(i >= 21 && i <= 23), BASE + 32'(m_k));
            if (i == 22) check("bp_ready_gap", io_in_ready, 1);
            if (i == 23) check("bp_no_en_gap", io_configs_en, 0);
            if (i == 26) check("bp_w5_en", io_configs_en, 25'h20);
            if (i == 102) check("bp_w24_en", io_configs_en, 25'h100_0000);
            if (i == 104) check("bp_done", io_done, 1);
        end
        // Start pulses while busy: at word 3, word 24 and in DONE
        drive(1, 0, 1, BASE);
        for (int i = 1; i <= 105; i++) begin
            drive(i == 13 || i == 97 || i == 101, 0, 1, BASE + 32'(m_k));
            if (i == 15) check("sb_w3_en", io_configs_en, 25'h8);
            if (i == 99) check("sb_w24_en", io_configs_en, 25'h100_0000);
            if (i == 101) check("sb_done", io_done, 1);
            if (i == 102) check("sb_no_restart", io_busy, 0);
            if (i == 102) check("sb_count", io_word_count, 25);
        end
        // Reset during word 10's SETUP, then restart
        drive(1, 0, 1, BASE);
        for (int i = 1; i <= 150; i++) begin
            drive(i == 44, i == 42, 1, BASE + 32'(m_k));
            if (i == 42) check("mr_setup_dout", io_d_out, BASE + 32'd10);
            if (i == 43) check("mr_busy", io_busy, 0);
            if (i == 43) check("mr_dout", io_d_out, 0);
            if (i == 43) check("mr_count", io_word_count, 0);
            if (i == 43) check("mr_ready", io_in_ready, 0);
            if (i == 47) check("mr_restart_w0", io_configs_en, 25'h1);
        end
        // Random valid, data, start and occasional reset
        for (int i = 0; i < 1200; i++)
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0,
                  $urandom_range(0, 3) != 0, $urandom);
        drive(0, 1, 0, '0);
        drive(0, 0, 0, '0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/config_word_loader.md
# config_word_loader

Upstream sequencer for the configuration latch bank. It accepts 32-bit configuration words over a valid/ready stream and writes them into the 25 level-sensitive latch groups (800 configuration bits) in order, word 0 to word 24. Each write drives the shared data bus, then a single one-hot enable pulse, then holds the data, so the latches see stable data for the whole transparent window. Per-load `io_busy`, `io_done` and a word counter let the tile controller track progress.

## Interface
- `WORD_W`, 32: configuration word width; equals the latch bank data width.
- `NUM_WORDS`, 25: number of latch groups, which is also the `io_configs_en` width.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `io_start`  in  1  begins a full load; sampled only in IDLE.
- `io_in_valid`  in  1  input word valid.
- `io_in_ready`  out  1  block can accept a word; high only in LOAD.
- `io_in_bits`  in  WORD_W  configuration word.
- `io_d_out`  out  WORD_W  registered data to the latch bank `io_d_in`.
- `io_configs_en`  out  NUM_WORDS  registered one-hot latch enables to the bank `io_configs_en`.
- `io_busy`  out  1  high in every state except IDLE.
- `io_done`  out  1  one-cycle pulse when the final word's HOLD completes.
- `io_word_count`  out  5  number of words strobed in the current/last load.

## Operation
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DONE. All outputs come from registers.
- IDLE → LOAD when `io_start` = 1. On the same edge, the word index and `io_word_count` clear to 0. Otherwise stay in IDLE.
- LOAD: `io_in_ready` = 1. When `io_in_valid & io_in_ready`, capture `io_in_bits` into `io_d_out` and go to SETUP. Otherwise stay in LOAD and hold `io_d_out`.
- SETUP: `io_configs_en` = 0 and data is stable. Go to STROBE.
- STROBE: `io_configs_en` = 1 << index for exactly one cycle. Increment `io_word_count`. Go to HOLD.
- HOLD: `io_configs_en` = 0 and data is still held.
  - If index = NUM_WORDS-1, go to DONE.
  - Otherwise index++ and go to LOAD.
- DONE: `io_done` = 1 for one cycle, then go to IDLE.
- `io_d_out` changes only on a LOAD handshake. It keeps its value through IDLE after a load.
- `io_configs_en` is never multi-hot and is never nonzero outside STROBE.
- `io_start` is ignored in every state other than IDLE, including DONE.
- `io_in_bits` is ignored when no handshake occurs. Input words offered outside LOAD are not consumed.
- Index is 5 bits and never wraps: there are no strobes past index NUM_WORDS-1.
- Reset (any state, including mid-load):
  - Next cycle: IDLE, `io_d_out` = 0, `io_configs_en` = 0, `io_in_ready` = 0, `io_busy` = 0, `io_done` = 0, `io_word_count` = 0.
  - Latch contents already written are not cleared. A fresh `io_start` reloads all words.

## Timing
- Throughput: 4 cycles per word minimum (LOAD, SETUP, STROBE, HOLD). LOAD stretches by one cycle for each cycle `io_in_valid` is low.
- Data-to-enable setup is 1 cycle; enable-fall-to-data-change hold is at least 1 cycle.
- With `io_start` sampled at cycle 0 and `io_in_valid` held high:
  - Word k is accepted in cycle 1+4k and strobed in cycle 3+4k.
  - Word 24 is strobed in cycle 99.
  - `io_done` is high in cycle 101.
  - IDLE from cycle 102, and `io_busy` falls in cycle 102.
- `io_busy` rises the cycle after `io_start` is sampled.

## Test plan
- **Full load, valid always high**, words = 32'hC0DE_0000 + k:
  - `io_configs_en` = 1 << k in cycle 3+4k, with `io_d_out` = 32'hC0DE_0000 + k in cycles 2+4k..4+4k.
  - `io_done` is high in cycle 101 only, and `io_word_count` = 25 afterwards.
- **Backpressure:** drop `io_in_valid` for 3 cycles before word 5.
  - `io_in_ready` stays high and no enable is asserted during the gap.
  - Word 5 strobes 3 cycles later than nominal; every later word shifts by 3.
- **Start while busy:** pulse `io_start` at words 3 and 24 and in DONE.
  - No restart, index unaffected, and the 25 strobes complete normally.
- **Reset mid-load** after word 10's SETUP:
  - Next cycle: all outputs 0 and state IDLE.
  - A new start strobes word 0 first (`io_configs_en` = 25'h1).
- **Idle stimulus:** drive `io_in_valid` = 1 with `io_in_bits` = 32'hFFFF_FFFF in IDLE.
  - `io_in_ready` = 0, `io_d_out` unchanged, `io_configs_en` = 0.
- **Invariant monitor over all tests:** `$onehot0(io_configs_en)` holds every cycle, and the enable is never high in consecutive cycles.
